// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit of the 8-bit core.
// Holds the state enum, opcode, ALU2-select and ALUOp constants, and the control-word layout.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExec   = 4'd3,
    StWb     = 4'd4,
    StMemRd  = 4'd5,
    StMemWb  = 4'd6,
    StMemWr  = 4'd7,
    StBranch = 4'd8
  } state_e;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpAddi = 3'b011;
  localparam logic [2:0] OpLw   = 3'b100;
  localparam logic [2:0] OpSw   = 3'b101;
  localparam logic [2:0] OpBz   = 3'b110;
  localparam logic [2:0] OpShl  = 3'b111;

  localparam logic [2:0] Alu2OpB  = 3'b000;
  localparam logic [2:0] Alu2One  = 3'b001;
  localparam logic [2:0] Alu2Imm4 = 3'b010;
  localparam logic [2:0] Alu2Imm5 = 3'b011;
  localparam logic [2:0] Alu2Imm3 = 3'b100;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluSub  = 2'b01;
  localparam logic [1:0] AluNand = 2'b10;
  localparam logic [1:0] AluShl  = 2'b11;

  typedef struct packed {
    logic       addr_sel;
    logic       opa_sel;
    logic       reg_in;
    logic       alu1;
    logic [2:0] alu2;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
  } ctrl_out_t;

  // ALU operand-2 select used in EXEC for the register/immediate ALU instructions.
  function automatic logic [2:0] exec_alu2(input logic [2:0] opcode);
    unique case (opcode)
      OpAddi:  return Alu2Imm4;
      OpShl:   return Alu2Imm3;
      default: return Alu2OpB;
    endcase
  endfunction

  function automatic logic [1:0] exec_alu_op(input logic [2:0] opcode);
    unique case (opcode)
      OpSub:   return AluSub;
      OpNand:  return AluNand;
      OpShl:   return AluShl;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
// Carries IR opcode and status inputs up, select lines and write strobes down.
interface control_fsm_if;

  logic [2:0] opcode;
  logic       opa_zero;
  logic       mem_ready;

  logic       AddrSel;
  logic       OpASel;
  logic       RegIn;
  logic       ALU1;
  logic [2:0] ALU2;
  logic [1:0] ALUOp;
  logic       PCWrite;
  logic       IRWrite;
  logic       MDRWrite;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       instr_done;

  modport master (
    input  opcode, opa_zero, mem_ready,
    output AddrSel, OpASel, RegIn, ALU1, ALU2, ALUOp,
    output PCWrite, IRWrite, MDRWrite, RegWrite, MemRead, MemWrite, instr_done
  );

  modport slave (
    output opcode, opa_zero, mem_ready,
    input  AddrSel, OpASel, RegIn, ALU1, ALU2, ALUOp,
    input  PCWrite, IRWrite, MDRWrite, RegWrite, MemRead, MemWrite, instr_done
  );

endinterface

// File: rtl/ctrl_out_decode.sv
// Moore output decode: state (plus opcode) selects the control word; only the
// memory-ready and branch-zero strobes look at live inputs in the same cycle.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] opcode,
  input  logic       opa_zero,
  input  logic       mem_ready,
  output ctrl_out_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu2     = Alu2One;
        ctrl.alu_op   = AluAdd;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      StDecode: begin
        ctrl.opa_sel = (opcode == OpBz);
      end
      StExec: begin
        ctrl.alu1   = 1'b1;
        ctrl.alu2   = exec_alu2(opcode);
        ctrl.alu_op = exec_alu_op(opcode);
      end
      StWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemRd: begin
        ctrl.mem_read  = 1'b1;
        ctrl.addr_sel  = 1'b1;
        ctrl.mdr_write = mem_ready;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_in     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write  = 1'b1;
        ctrl.addr_sel   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      StBranch: begin
        // PC already holds PC+1 from FETCH, so the target is relative to it.
        ctrl.opa_sel    = 1'b1;
        ctrl.alu2       = Alu2Imm5;
        ctrl.alu_op     = AluAdd;
        ctrl.pc_write   = opa_zero;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: state register and next-state logic; the output
// decode lives in ctrl_out_decode.
module control_fsm
  import ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  state_e    state_q, state_d;
  ctrl_out_t ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStart;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StStart:  state_d = StFetch;
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpBz:    state_d = StBranch;
          OpLw:    state_d = StMemRd;
          OpSw:    state_d = StMemWr;
          default: state_d = StExec;
        endcase
      end
      StExec:   state_d = StWb;
      StWb:     state_d = StFetch;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StStart;
    endcase
  end

  ctrl_out_decode u_out_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .opa_zero  (bus.opa_zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.AddrSel    = ctrl.addr_sel;
  assign bus.OpASel     = ctrl.opa_sel;
  assign bus.RegIn      = ctrl.reg_in;
  assign bus.ALU1       = ctrl.alu1;
  assign bus.ALU2       = ctrl.alu2;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.MDRWrite   = ctrl.mdr_write;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle table of inputs and expected control words,
// plus a hand-written SW wait / reset-abort sequence.
module tb_control_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;

  control_fsm_if bus ();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {AddrSel, OpASel, RegIn, ALU1, ALU2[2:0], ALUOp[1:0],
  //  PCWrite, IRWrite, MDRWrite, RegWrite, MemRead, MemWrite, instr_done}
  logic [15:0] act;
  assign act = {bus.AddrSel, bus.OpASel, bus.RegIn, bus.ALU1, bus.ALU2, bus.ALUOp,
                bus.PCWrite, bus.IRWrite, bus.MDRWrite, bus.RegWrite, bus.MemRead,
                bus.MemWrite, bus.instr_done};

  localparam logic [15:0] E_ZERO    = 16'h0000;
  localparam logic [15:0] E_FETCH_W = {4'b0000, 3'b001, 2'b00, 7'b0000100};
  localparam logic [15:0] E_FETCH   = {4'b0000, 3'b001, 2'b00, 7'b1100100};
  localparam logic [15:0] E_DEC_BZ  = {4'b0100, 3'b000, 2'b00, 7'b0000000};
  localparam logic [15:0] E_EX_ADD  = {4'b0001, 3'b000, 2'b00, 7'b0000000};
  localparam logic [15:0] E_EX_SUB  = {4'b0001, 3'b000, 2'b01, 7'b0000000};
  localparam logic [15:0] E_EX_NAND = {4'b0001, 3'b000, 2'b10, 7'b0000000};
  localparam logic [15:0] E_EX_ADDI = {4'b0001, 3'b010, 2'b00, 7'b0000000};
  localparam logic [15:0] E_EX_SHL  = {4'b0001, 3'b100, 2'b11, 7'b0000000};
  localparam logic [15:0] E_WB      = {4'b0000, 3'b000, 2'b00, 7'b0001001};
  localparam logic [15:0] E_RD_W    = {4'b1000, 3'b000, 2'b00, 7'b0000100};
  localparam logic [15:0] E_RD      = {4'b1000, 3'b000, 2'b00, 7'b0010100};
  localparam logic [15:0] E_MEM_WB  = {4'b0010, 3'b000, 2'b00, 7'b0001001};
  localparam logic [15:0] E_WR_W    = {4'b1000, 3'b000, 2'b00, 7'b0000010};
  localparam logic [15:0] E_WR      = {4'b1000, 3'b000, 2'b00, 7'b0000011};
  localparam logic [15:0] E_BR_T    = {4'b0100, 3'b011, 2'b00, 7'b1000001};
  localparam logic [15:0] E_BR_N    = {4'b0100, 3'b011, 2'b00, 7'b0000001};

  typedef struct {
    logic        rst;
    logic [2:0]  opc;
    logic        z;
    logic        rdy;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic [2:0] opc, input logic z, input logic rdy,
                     input logic [15:0] exp, input string name);
    vec_t v;
    v.rst = r; v.opc = opc; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs at the falling edge, then compare the control word.
  task automatic step(input logic r, input logic [2:0] opc, input logic z, input logic rdy,
                      input logic [15:0] exp, input string name);
    @(negedge clk);
    reset         = r;
    bus.opcode    = opc;
    bus.opa_zero  = z;
    bus.mem_ready = rdy;
    #1;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    bus.opcode    = 3'b000;
    bus.opa_zero  = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset for two cycles, release, first fetch.
    add(1, 3'b000, 0, 1, E_ZERO,    "reset_c1");
    add(1, 3'b000, 0, 1, E_ZERO,    "reset_c2");
    add(0, 3'b000, 0, 1, E_ZERO,    "start");
    // ADD, zero wait; mem_ready low outside memory states must not matter.
    add(0, 3'b000, 0, 1, E_FETCH,   "add_fetch");
    add(0, 3'b000, 0, 0, E_ZERO,    "add_decode");
    add(0, 3'b000, 0, 0, E_EX_ADD,  "add_exec");
    add(0, 3'b000, 0, 0, E_WB,      "add_wb");
    // LW with three wait cycles in MEM_RD.
    add(0, 3'b100, 0, 1, E_FETCH,   "lw_fetch");
    add(0, 3'b100, 0, 1, E_ZERO,    "lw_decode");
    add(0, 3'b100, 0, 0, E_RD_W,    "lw_rd_w1");
    add(0, 3'b100, 0, 0, E_RD_W,    "lw_rd_w2");
    add(0, 3'b100, 0, 0, E_RD_W,    "lw_rd_w3");
    add(0, 3'b100, 0, 1, E_RD,      "lw_rd_done");
    add(0, 3'b100, 0, 0, E_MEM_WB,  "lw_mem_wb");
    // BZ taken then not taken.
    add(0, 3'b110, 1, 1, E_FETCH,   "bz1_fetch");
    add(0, 3'b110, 1, 1, E_DEC_BZ,  "bz1_decode");
    add(0, 3'b110, 1, 0, E_BR_T,    "bz1_branch");
    add(0, 3'b110, 0, 1, E_FETCH,   "bz0_fetch");
    add(0, 3'b110, 0, 1, E_DEC_BZ,  "bz0_decode");
    add(0, 3'b110, 0, 1, E_BR_N,    "bz0_branch");
    // SHL, then ADDI.
    add(0, 3'b111, 0, 1, E_FETCH,   "shl_fetch");
    add(0, 3'b111, 0, 1, E_ZERO,    "shl_decode");
    add(0, 3'b111, 0, 1, E_EX_SHL,  "shl_exec");
    add(0, 3'b111, 0, 1, E_WB,      "shl_wb");
    add(0, 3'b011, 0, 1, E_FETCH,   "addi_fetch");
    add(0, 3'b011, 0, 1, E_ZERO,    "addi_decode");
    add(0, 3'b011, 0, 1, E_EX_ADDI, "addi_exec");
    add(0, 3'b011, 0, 1, E_WB,      "addi_wb");
    // SUB with one FETCH wait, then NAND.
    add(0, 3'b001, 0, 0, E_FETCH_W, "sub_fetch_w");
    add(0, 3'b001, 0, 1, E_FETCH,   "sub_fetch");
    add(0, 3'b001, 0, 1, E_ZERO,    "sub_decode");
    add(0, 3'b001, 0, 1, E_EX_SUB,  "sub_exec");
    add(0, 3'b001, 0, 1, E_WB,      "sub_wb");
    add(0, 3'b010, 0, 1, E_FETCH,   "nand_fetch");
    add(0, 3'b010, 0, 1, E_ZERO,    "nand_decode");
    add(0, 3'b010, 0, 1, E_EX_NAND, "nand_exec");
    add(0, 3'b010, 0, 1, E_WB,      "nand_wb");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].opc, vecs[i].z, vecs[i].rdy, vecs[i].exp, vecs[i].name);
    end

    // SW stalled in MEM_WR, aborted by reset: no instr_done, MemWrite drops next cycle.
    step(0, 3'b101, 0, 1, E_FETCH,  "sw_fetch");
    step(0, 3'b101, 0, 1, E_ZERO,   "sw_decode");
    step(0, 3'b101, 0, 0, E_WR_W,   "sw_wr_w1");
    step(0, 3'b101, 0, 0, E_WR_W,   "sw_wr_w2");
    step(1, 3'b101, 0, 0, E_WR_W,   "sw_wr_rst");
    step(0, 3'b101, 0, 1, E_ZERO,   "sw_abort_start");
    // Zero-wait SW completes in three cycles.
    step(0, 3'b101, 0, 1, E_FETCH,  "sw2_fetch");
    step(0, 3'b101, 0, 1, E_ZERO,   "sw2_decode");
    step(0, 3'b101, 0, 1, E_WR,     "sw2_wr");
    step(0, 3'b000, 0, 0, E_FETCH_W, "sw2_next_fetch");
    // Reset during a FETCH wait.
    step(1, 3'b000, 0, 0, E_FETCH_W, "fetch_rst");
    step(0, 3'b000, 0, 0, E_ZERO,   "fetch_rst_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
